// File: rtl/fetch_ctrl.sv
// Fetch/sequencing controller: fetches at pc_in, hands the word to the datapath, then steps the PC.
// Optional fetch-wait watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_pc_in,
  output logic [15:0] o_imem_addr,
  output logic        o_imem_req,
  input  logic        i_imem_ready,
  input  logic [15:0] i_imem_rdata,
  output logic [15:0] o_ir_out,
  output logic        o_ir_valid,
  input  logic        i_exec_done,
  input  logic        i_zero_flag,
  output logic        o_pc_en,
  output logic [1:0]  o_pc_ctrl,
  output logic [7:0]  o_offset_addr,
  output logic        o_halted,
  output logic        o_fault
);

  localparam logic [4:0] OP_HALT = 5'b00001;
  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_BZ   = 5'b11001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_UPDATE,
    ST_HALT
`ifdef FETCH_TIMEOUT_EN
    , ST_FAULT
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic [1:0]  r_upd_ctrl;
  logic [1:0]  w_upd;
  logic [4:0]  w_opcode;
  logic        w_tmo_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fetch_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  assign w_opcode    = r_ir[15:11];
  assign o_imem_addr = i_pc_in;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  // Counts consecutive FETCH cycles with no ready; any exit from FETCH clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_FETCH && !i_imem_ready) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_upd = 2'b01;
    if (w_opcode == OP_JMP) begin
      w_upd = 2'b10;
    end else if (w_opcode == OP_BZ && i_zero_flag) begin
      w_upd = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ir       <= '0;
      r_upd_ctrl <= 2'b00;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH && i_imem_ready) begin
        r_ir <= i_imem_rdata;
      end
      if (r_state == ST_EXEC && i_exec_done) begin
        r_upd_ctrl <= w_upd;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    o_imem_req = 1'b0;
    o_ir_valid = 1'b0;
    o_pc_en    = 1'b0;
    o_pc_ctrl  = 2'b00;
    o_halted   = 1'b0;
    o_fault    = 1'b0;
    o_ir_out   = r_ir;
    case (r_state)
      ST_IDLE: w_next = ST_FETCH;
      ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          w_next = ST_DECODE;
        end else if (w_tmo_hit) begin
`ifdef FETCH_TIMEOUT_EN
          w_next = ST_FAULT;
`endif
        end
      end
      ST_DECODE: w_next = (w_opcode == OP_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        o_ir_valid = 1'b1;
        if (i_exec_done) begin
          w_next = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        o_pc_en   = 1'b1;
        o_pc_ctrl = r_upd_ctrl;
        w_next    = ST_FETCH;
      end
      ST_HALT: o_halted = 1'b1;
`ifdef FETCH_TIMEOUT_EN
      // A faulted controller presents nothing but the fault flag.
      ST_FAULT: begin
        o_fault  = 1'b1;
        o_ir_out = '0;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_offset_addr = o_ir_out[7:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: the bench owns the PC register and checks each
// instruction's handshake sequence and PC update against a per-instruction reference model.
module tb_fetch_ctrl;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] o_imem_addr;
  logic        o_imem_req;
  logic        i_imem_ready;
  logic [15:0] i_imem_rdata;
  logic [15:0] o_ir_out;
  logic        o_ir_valid;
  logic        i_exec_done;
  logic        i_zero_flag;
  logic        o_pc_en;
  logic [1:0]  o_pc_ctrl;
  logic [7:0]  o_offset_addr;
  logic        o_halted;
  logic        o_fault;

  int nCompared   = 0;
  int nMismatched = 0;

  fetch_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_pc_in       (pc),
    .o_imem_addr   (o_imem_addr),
    .o_imem_req    (o_imem_req),
    .i_imem_ready  (i_imem_ready),
    .i_imem_rdata  (i_imem_rdata),
    .o_ir_out      (o_ir_out),
    .o_ir_valid    (o_ir_valid),
    .i_exec_done   (i_exec_done),
    .i_zero_flag   (i_zero_flag),
    .o_pc_en       (o_pc_en),
    .o_pc_ctrl     (o_pc_ctrl),
    .o_offset_addr (o_offset_addr),
    .o_halted      (o_halted),
    .o_fault       (o_fault)
  );

  always #5 clk = ~clk;

  // Reference: what the PC should be told to do once an instruction completes.
  function automatic logic [1:0] refCtrl(input logic [15:0] w, input logic z);
    if (w[15:11] == 5'b11000) return 2'b10;
    if (w[15:11] == 5'b11001) return z ? 2'b10 : 2'b01;
    return 2'b01;
  endfunction

  function automatic logic [15:0] refNextPc(input logic [15:0] p, input logic [15:0] w, input logic z);
    return (refCtrl(w, z) == 2'b10) ? {8'h00, w[7:0]} : p + 16'd1;
  endfunction

  // One clock: the bench PC register applies whatever the DUT presented during the cycle.
  task automatic tick();
    logic       en;
    logic [1:0] c;
    logic [7:0] off;
    en  = o_pc_en;
    c   = o_pc_ctrl;
    off = o_offset_addr;
    @(posedge clk);
    if (en) begin
      if (c == 2'b01) pc = pc + 16'd1;
      else if (c == 2'b10) pc = {8'h00, off};
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_imem_ready = 1'b0;
    i_exec_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tick();
  endtask

  // Runs one instruction starting in FETCH; ends in the next FETCH (or HALT).
  task automatic run_instr(input logic [15:0] w, input int memWait, input int execWait, input logic z);
    logic [15:0] startPc;
    logic [15:0] expPc;
    logic [1:0]  expCtrl;
    startPc = pc;
    expCtrl = refCtrl(w, z);
    expPc   = refNextPc(startPc, w, z);
    for (int i = 0; i <= memWait; i++) begin
      nCompared++;
      if (o_imem_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL fetch_req: got %b want 1", o_imem_req); end
      nCompared++;
      if (o_imem_addr !== startPc) begin nMismatched++; $display("[TB] FAIL fetch_addr: got %h want %h", o_imem_addr, startPc); end
      i_imem_ready = (i == memWait);
      i_imem_rdata = (i == memWait) ? w : 16'($urandom);
      i_exec_done  = 1'($urandom);
      tick();
    end
    i_imem_ready = 1'b0;
    i_exec_done  = 1'b0;
    nCompared++;
    if (o_ir_out !== w) begin nMismatched++; $display("[TB] FAIL decode_ir: got %h want %h", o_ir_out, w); end
    nCompared++;
    if ({o_imem_req, o_ir_valid, o_pc_en} !== 3'b000) begin
      nMismatched++; $display("[TB] FAIL decode_outs: got req/valid/en=%b want 000", {o_imem_req, o_ir_valid, o_pc_en});
    end
    i_imem_ready = 1'($urandom);
    tick();
    i_imem_ready = 1'b0;
    if (w[15:11] == 5'b00001) begin
      nCompared++;
      if ({o_halted, o_pc_en, o_imem_req, o_ir_valid} !== 4'b1000) begin
        nMismatched++; $display("[TB] FAIL halt_entry: got halted/en/req/valid=%b want 1000", {o_halted, o_pc_en, o_imem_req, o_ir_valid});
      end
      return;
    end
    for (int i = 0; i <= execWait; i++) begin
      nCompared++;
      if ({o_ir_valid, o_pc_en, o_imem_req} !== 3'b100) begin
        nMismatched++; $display("[TB] FAIL exec_outs: got valid/en/req=%b want 100", {o_ir_valid, o_pc_en, o_imem_req});
      end
      i_exec_done  = (i == execWait);
      i_zero_flag  = (i == execWait) ? z : ~z;
      i_imem_ready = 1'($urandom);
      tick();
    end
    i_exec_done  = 1'b0;
    i_imem_ready = 1'b0;
    nCompared++;
    if (o_pc_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL update_en: got %b want 1", o_pc_en); end
    nCompared++;
    if (o_pc_ctrl !== expCtrl) begin nMismatched++; $display("[TB] FAIL update_ctrl: got %b want %b", o_pc_ctrl, expCtrl); end
    nCompared++;
    if (o_offset_addr !== w[7:0]) begin nMismatched++; $display("[TB] FAIL update_offset: got %h want %h", o_offset_addr, w[7:0]); end
    tick();
    nCompared++;
    if (pc !== expPc) begin nMismatched++; $display("[TB] FAIL next_pc: got %h want %h", pc, expPc); end
    nCompared++;
    if ({o_imem_req, o_pc_en} !== 2'b10 || o_imem_addr !== expPc) begin
      nMismatched++; $display("[TB] FAIL next_fetch: got req/en=%b addr=%h want 10 addr=%h", {o_imem_req, o_pc_en}, o_imem_addr, expPc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pc = 16'h0005;
    i_imem_ready = 1'b0;
    i_imem_rdata = 16'h0000;
    i_exec_done = 1'b0;
    i_zero_flag = 1'b0;
    #1;
    nCompared++;
    if ({o_imem_req, o_ir_valid, o_pc_en, o_pc_ctrl, o_halted, o_fault} !== 7'b0 || o_ir_out !== 16'h0 || o_offset_addr !== 8'h0) begin
      nMismatched++; $display("[TB] FAIL reset_state: got req/valid/en/ctrl/halt/fault=%b ir=%h", {o_imem_req, o_ir_valid, o_pc_en, o_pc_ctrl, o_halted, o_fault}, o_ir_out);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nCompared++;
    if (o_imem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_req: got %b want 0", o_imem_req); end
    tick();
    nCompared++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== pc) begin
      nMismatched++; $display("[TB] FAIL first_fetch: got req=%b addr=%h want 1 addr=%h", o_imem_req, o_imem_addr, pc);
    end
  endtask

  task automatic test_directed();
    run_instr(16'h0012, 0, 0, 1'b0);
    run_instr(16'hC0A7, 0, 0, 1'b0);
    run_instr(16'hC833, 0, 0, 1'b1);
    run_instr(16'hC833, 1, 2, 1'b0);
  endtask

  task automatic test_halt();
    run_instr(16'h0800, 0, 0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      i_imem_ready = 1'($urandom);
      i_exec_done  = 1'($urandom);
      i_imem_rdata = 16'($urandom);
      tick();
      nCompared++;
      if ({o_halted, o_pc_en, o_imem_req, o_pc_ctrl} !== 5'b10000) begin
        nMismatched++; $display("[TB] FAIL halt_hold: got halted/en/req/ctrl=%b want 10000", {o_halted, o_pc_en, o_imem_req, o_pc_ctrl});
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    pc = 16'h1234;
    #1;
    i_imem_ready = 1'b1;
    i_imem_rdata = 16'h0012;
    tick();
    i_imem_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    nCompared++;
    if ({o_imem_req, o_ir_valid, o_pc_en, o_halted} !== 4'b0 || o_ir_out !== 16'h0) begin
      nMismatched++; $display("[TB] FAIL midrun_reset: got req/valid/en/halt=%b ir=%h want 0", {o_imem_req, o_ir_valid, o_pc_en, o_halted}, o_ir_out);
    end
    do_reset();
    nCompared++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h1234) begin
      nMismatched++; $display("[TB] FAIL midrun_refetch: got req=%b addr=%h want 1 addr=1234", o_imem_req, o_imem_addr);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 3))
        0: w[15:11] = 5'b11000;
        1: w[15:11] = 5'b11001;
        default: if (w[15:11] == 5'b00001) w[15:11] = 5'b00000;
      endcase
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    i_imem_ready = 1'b0;
    for (int i = 1; i <= TIMEOUT_CYCLES - 1; i++) tick();
    nCompared++;
    if (o_fault !== 1'b0 || o_imem_req !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL pre_timeout: got fault=%b req=%b want 0 1", o_fault, o_imem_req);
    end
    tick();
    nCompared++;
    if ({o_fault, o_imem_req, o_pc_en, o_halted, o_ir_valid} !== 5'b10000 || o_ir_out !== 16'h0) begin
      nMismatched++; $display("[TB] FAIL timeout_fault: got fault/req/en/halt/valid=%b ir=%h want 10000", {o_fault, o_imem_req, o_pc_en, o_halted, o_ir_valid}, o_ir_out);
    end
    do_reset();
    for (int i = 1; i <= TIMEOUT_CYCLES - 2; i++) tick();
    i_imem_ready = 1'b1;
    i_imem_rdata = 16'h0012;
    tick();
    i_imem_ready = 1'b0;
    tick();
    nCompared++;
    if (o_fault !== 1'b0 || o_ir_valid !== 1'b1 || o_ir_out !== 16'h0012) begin
      nMismatched++; $display("[TB] FAIL late_ready: got fault=%b valid=%b ir=%h want 0 1 0012", o_fault, o_ir_valid, o_ir_out);
    end
  endtask
`else
  task automatic test_timeout();
    do_reset();
    i_imem_ready = 1'b0;
    for (int i = 0; i < 3 * TIMEOUT_CYCLES; i++) tick();
    nCompared++;
    if (o_fault !== 1'b0 || o_imem_req !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL long_wait: got fault=%b req=%b want 0 1", o_fault, o_imem_req);
    end
    run_instr(16'h0012, 0, 0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_halt();
    test_reset_midrun();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
